// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/retire front-end for the combinational 16-bit ALU.
// E stage drives the ALU inputs; R stage captures result/zero and presents a
// tagged response. Valid/ready on both sides, one op per cycle at full flow,
// at most two ops in flight under back-pressure.
module alu_issue #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int TAGW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_imm,
  input  logic             req_use_imm,
  input  logic [TAGW-1:0]  req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [TAGW-1:0]  rsp_tag,
  output logic [15:0]      retired_count
);

  logic             r_e_valid;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic [TAGW-1:0]  r_e_tag;

  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic [TAGW-1:0]  r_rsp_tag;

  logic [15:0]      r_retired;

  logic             w_r_load;
  logic             w_e_load;
  logic             w_rsp_fire;

  // R can take E's op when R is empty or draining this cycle; E is free when
  // empty or moving into R. No path from req_valid to req_ready.
  assign w_r_load   = r_e_valid && (!r_rsp_valid || rsp_ready);
  assign req_ready  = !r_e_valid || w_r_load;
  assign w_e_load   = req_valid && req_ready;
  assign w_rsp_fire = r_rsp_valid && rsp_ready;

  // E stage: register operands/opcode onto the ALU inputs; payload holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_valid <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_e_tag   <= '0;
    end else begin
      if (w_e_load) begin
        r_e_valid <= 1'b1;
        r_alu_a   <= req_a;
        r_alu_b   <= req_use_imm ? req_imm : req_b;
        r_alu_op  <= req_op;
        r_e_tag   <= req_tag;
      end else if (w_r_load) begin
        r_e_valid <= 1'b0;
      end
    end
  end

  // R stage: capture ALU result one cycle after issue; payload frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_tag    <= '0;
    end else begin
      if (w_r_load) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_rsp_tag    <= r_e_tag;
      end else if (rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  // Retire counter: one per response handshake, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_retired <= '0;
    else if (w_rsp_fire) r_retired <= r_retired + 16'd1;
  end

  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_zero      = r_rsp_zero;
  assign rsp_tag       = r_rsp_tag;
  assign retired_count = r_retired;

endmodule
